// File: rtl/window_gen_pkg.sv
// window_gen_pkg: pixel/window types and constants shared by the window producer and its consumers
package window_gen_pkg;
  localparam int DATA_BW = 8;
  localparam int WIN_PIX = 9;
  typedef logic [DATA_BW-1:0] pix_t;
  typedef pix_t [WIN_PIX-1:0] win_t;
  function automatic logic [DATA_BW*WIN_PIX-1:0] pack_win(input win_t w);
    logic [DATA_BW*WIN_PIX-1:0] r;
    r = '0;
    for (int i = 0; i < WIN_PIX; i++) r[DATA_BW*(WIN_PIX-1-i) +: DATA_BW] = w[i];
    return r;
  endfunction
endpackage

// File: rtl/window_gen_if.sv
// window_gen_if: pixel-in / window-out DXI streams; o_dxi_out_last exists only with WINDOW_GEN_LAST_EN
interface window_gen_if #(parameter int DATA_BW = 8);
  logic                 i_dxi_in_valid;
  logic [DATA_BW-1:0]   i_dxi_in_data;
  logic                 o_dxi_in_ready;
  logic                 o_dxi_out_valid;
  logic [DATA_BW*9-1:0] o_dxi_out_data;
  logic                 i_dxi_out_ready;
`ifdef WINDOW_GEN_LAST_EN
  logic                 o_dxi_out_last;
`endif
  modport slave (
    input  i_dxi_in_valid, i_dxi_in_data, i_dxi_out_ready,
    output o_dxi_in_ready, o_dxi_out_valid, o_dxi_out_data
`ifdef WINDOW_GEN_LAST_EN
    , output o_dxi_out_last
`endif
  );
  modport master (
    output i_dxi_in_valid, i_dxi_in_data, i_dxi_out_ready,
    input  o_dxi_in_ready, o_dxi_out_valid, o_dxi_out_data
`ifdef WINDOW_GEN_LAST_EN
    , input o_dxi_out_last
`endif
  );
endinterface

// File: rtl/window_gen_line_buffer.sv
// line_buffer: one-line pixel store, async read-before-write at a shared address
module line_buffer #(
  parameter int DATA_BW = 8,
  parameter int DEPTH   = 640,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      addr,
  input  logic [DATA_BW-1:0] din,
  output logic [DATA_BW-1:0] dout
);
  logic [DATA_BW-1:0] mem [DEPTH];
  assign dout = mem[addr];
  always_ff @(posedge clk)
    if (we) mem[addr] <= din;
endmodule

// File: rtl/window_gen.sv
// window_gen: raster pixels to interior 3x3 windows, one output register stage
// Optional frame-end marker o_dxi_out_last under WINDOW_GEN_LAST_EN.
module window_gen
  import window_gen_pkg::*;
#(
  parameter int DATA_BW    = window_gen_pkg::DATA_BW,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input logic i_clk,
  input logic i_rst,
  window_gen_if.slave dxi
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic [DATA_BW-1:0] win [WIN_PIX];
  logic [DATA_BW-1:0] nxt [WIN_PIX];
  logic [DATA_BW-1:0] lb1_rd, lb2_rd;
  logic [DATA_BW*WIN_PIX-1:0] nxt_flat, out_data;
  logic accept, emit, col_end, row_end, out_valid;
  assign dxi.o_dxi_in_ready  = !out_valid || dxi.i_dxi_out_ready;
  assign dxi.o_dxi_out_valid = out_valid;
  assign dxi.o_dxi_out_data  = out_data;
  assign accept  = dxi.i_dxi_in_valid && dxi.o_dxi_in_ready;
  assign col_end = col_cnt == CW'(IMG_WIDTH-1);
  assign row_end = row_cnt == RW'(IMG_HEIGHT-1);
  assign emit    = accept && row_cnt >= RW'(2) && col_cnt >= CW'(2);
  line_buffer #(.DATA_BW(DATA_BW), .DEPTH(IMG_WIDTH)) lb1 (
    .clk(i_clk), .we(accept), .addr(col_cnt), .din(dxi.i_dxi_in_data), .dout(lb1_rd));
  line_buffer #(.DATA_BW(DATA_BW), .DEPTH(IMG_WIDTH)) lb2 (
    .clk(i_clk), .we(accept), .addr(col_cnt), .din(lb1_rd), .dout(lb2_rd));
  // Window as it will look once the current pixel lands: shifted left, new right column.
  always_comb begin
    nxt[0] = win[1];
    nxt[1] = win[2];
    nxt[2] = lb2_rd;
    nxt[3] = win[4];
    nxt[4] = win[5];
    nxt[5] = lb1_rd;
    nxt[6] = win[7];
    nxt[7] = win[8];
    nxt[8] = dxi.i_dxi_in_data;
    nxt_flat = '0;
    for (int i = 0; i < WIN_PIX; i++) nxt_flat[DATA_BW*(WIN_PIX-1-i) +: DATA_BW] = nxt[i];
  end
`ifdef WINDOW_GEN_LAST_EN
  logic out_last;
  assign dxi.o_dxi_out_last = out_last;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) out_last <= 1'b0;
    else if (emit) out_last <= row_end && col_end;
`endif
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      col_cnt   <= '0;
      row_cnt   <= '0;
      win       <= '{default: '0};
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (accept) begin
        col_cnt <= col_end ? '0 : col_cnt + 1'b1;
        if (col_end) row_cnt <= row_end ? '0 : row_cnt + 1'b1;
        win <= nxt;
      end
      if (emit) begin
        out_valid <= 1'b1;
        out_data  <= nxt_flat;
      end else if (dxi.i_dxi_out_ready) out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_window_gen.sv
// tb_window_gen: directed checks of window_gen on a 4x4 image; define WINDOW_GEN_LAST_EN to cover the frame marker
module tb_window_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  window_gen_if #(.DATA_BW(8)) dxi ();
  window_gen #(.DATA_BW(8), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut (.i_clk(clk), .i_rst(rst), .dxi(dxi));
  localparam logic [71:0] W [4] = '{
    72'h00_01_02_04_05_06_08_09_0A,
    72'h01_02_03_05_06_07_09_0A_0B,
    72'h04_05_06_08_09_0A_0C_0D_0E,
    72'h05_06_07_09_0A_0B_0D_0E_0F};
  localparam int T [4] = '{11, 12, 15, 16};
  int errors = 0;
  int checks = 0;
  int acc = 0;
  logic [71:0] got_q [$];
  int tag_q [$];
  logic last_q [$];
  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // A handshake seen at a negedge completes on the following posedge.
  always @(negedge clk) begin
    if (dxi.o_dxi_out_valid && dxi.i_dxi_out_ready) begin
      got_q.push_back(dxi.o_dxi_out_data);
      tag_q.push_back(acc);
`ifdef WINDOW_GEN_LAST_EN
      last_q.push_back(dxi.o_dxi_out_last);
`else
      last_q.push_back(1'b0);
`endif
    end
    if (dxi.i_dxi_in_valid && dxi.o_dxi_in_ready) acc++;
  end
  task automatic clear();
    got_q.delete();
    tag_q.delete();
    last_q.delete();
    acc = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send(input logic [7:0] p);
    int n = 0;
    dxi.i_dxi_in_valid = 1'b1;
    dxi.i_dxi_in_data  = p;
    @(negedge clk);
    while (!dxi.o_dxi_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("send_timeout", 72'(n), 72'(0));
    @(posedge clk);
    #1;
    dxi.i_dxi_in_valid = 1'b0;
    dxi.i_dxi_in_data  = 8'hEE;
  endtask
  task automatic frame(input bit gaps);
    for (int i = 0; i < 16; i++) begin
      send(8'(i));
      if (gaps) idle($urandom_range(0, 3));
    end
  endtask
  task automatic check_windows(input string tag, input int nfr);
    int n;
    idle(4);
    check({tag, "_count"}, 72'(got_q.size()), 72'(4*nfr));
    n = got_q.size() < 4*nfr ? got_q.size() : 4*nfr;
    for (int k = 0; k < n; k++) begin
      check({tag, "_data"}, got_q[k], W[k%4]);
      check({tag, "_after_pixels"}, 72'(tag_q[k]), 72'(T[k%4] + 16*(k/4)));
`ifdef WINDOW_GEN_LAST_EN
      check({tag, "_last"}, 72'(last_q[k]), 72'(k%4 == 3));
`endif
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    dxi.i_dxi_in_valid  = 1'b0;
    dxi.i_dxi_in_data   = 8'h00;
    dxi.i_dxi_out_ready = 1'b1;
    #2;
    check("rst_valid", 72'(dxi.o_dxi_out_valid), 72'(0));
    check("rst_data", dxi.o_dxi_out_data, 72'(0));
    idle(2);
    rst = 1'b0;
    check("rst_in_ready", 72'(dxi.o_dxi_in_ready), 72'(1));
    // back-to-back single frame
    clear();
    frame(0);
    check_windows("t1", 1);
    // output backpressure on the first window
    clear();
    dxi.i_dxi_out_ready = 1'b0;
    fork
      frame(0);
      begin
        int n = 0;
        while (!dxi.o_dxi_out_valid && n < 100) begin
          @(negedge clk);
          n++;
        end
        check("bp_wait", 72'(n < 100), 72'(1));
        repeat (5) begin
          check("bp_data", dxi.o_dxi_out_data, W[0]);
          check("bp_in_ready", 72'(dxi.o_dxi_in_ready), 72'(0));
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        dxi.i_dxi_out_ready = 1'b1;
      end
    join
    check_windows("t2", 1);
    // two frames back-to-back
    clear();
    frame(0);
    frame(0);
    check_windows("t3", 2);
    // random input gaps
    clear();
    frame(1);
    check_windows("t4", 1);
    // reset mid-frame, then reset with a window pending
    for (int i = 0; i < 8; i++) send(8'(i));
    rst = 1'b1;
    #1;
    check("t5_rst_valid", 72'(dxi.o_dxi_out_valid), 72'(0));
    idle(2);
    rst = 1'b0;
    dxi.i_dxi_out_ready = 1'b0;
    for (int i = 0; i < 11; i++) send(8'(i));
    check("t5_pending", 72'(dxi.o_dxi_out_valid), 72'(1));
    rst = 1'b1;
    #1;
    check("t5_drop_valid", 72'(dxi.o_dxi_out_valid), 72'(0));
    check("t5_drop_data", dxi.o_dxi_out_data, 72'(0));
    idle(2);
    rst = 1'b0;
    dxi.i_dxi_out_ready = 1'b1;
    clear();
    frame(0);
    check_windows("t5", 1);
`ifdef WINDOW_GEN_LAST_EN
    // frame marker held under backpressure
    clear();
    for (int i = 0; i < 15; i++) send(8'(i));
    dxi.i_dxi_out_ready = 1'b0;
    send(8'h0F);
    repeat (3) begin
      check("t6_last_held", 72'(dxi.o_dxi_out_last), 72'(1));
      check("t6_data_held", dxi.o_dxi_out_data, W[3]);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    dxi.i_dxi_out_ready = 1'b1;
    check_windows("t6", 1);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
